// File: rtl/mips_cpu_regfile_pkg.sv
// Shared types and the partial-load merge function for the MIPS register file.
// The memory-stage checker uses the same load_merge() so both agree on byte lanes.
package mips_cpu_regfile_pkg;

  typedef enum logic [2:0] {
    WM_WORD = 3'd0,
    WM_LB   = 3'd1,
    WM_LBU  = 3'd2,
    WM_LH   = 3'd3,
    WM_LHU  = 3'd4,
    WM_LWL  = 3'd5,
    WM_LWR  = 3'd6
  } wr_mode_e;

  typedef struct packed {
    logic [31:0] value;
    logic        illegal;
  } merge_t;

  // Little-endian lanes; LWL/LWR keep the register bits the load does not cover.
  function automatic merge_t load_merge(input logic [31:0] old_val,
                                        input logic [31:0] data,
                                        input logic [2:0]  mode,
                                        input logic [1:0]  offset);
    merge_t      r;
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh;
    logic [31:0] mask;
    r.value   = data;
    r.illegal = 1'b0;
    b         = data[{offset, 3'b000} +: 8];
    h         = offset[1] ? data[31:16] : data[15:0];
    sh        = '0;
    mask      = '0;
    case (mode)
      WM_LB:  r.value = {{24{b[7]}}, b};
      WM_LBU: r.value = {24'd0, b};
      WM_LH: begin
        r.value   = {{16{h[15]}}, h};
        r.illegal = offset[0];
      end
      WM_LHU: begin
        r.value   = {16'd0, h};
        r.illegal = offset[0];
      end
      WM_LWL: begin
        sh      = 5'd24 - {offset, 3'b000};
        mask    = 32'hFFFF_FFFF << sh;
        r.value = (old_val & ~mask) | (data << sh);
      end
      WM_LWR: begin
        sh      = {offset, 3'b000};
        mask    = 32'hFFFF_FFFF >> sh;
        r.value = (old_val & ~mask) | (data >> sh);
      end
      default: r.value = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_cpu_regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port,
// load reservation and debug tap.
interface mips_cpu_regfile_mp_if #(
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0] rd_addr;
  logic [NREAD*32-1:0] rd_data;
  logic [NREAD-1:0]    rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [2:0]          wr_mode;
  logic [1:0]          wr_offset;
  logic [31:0]         wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                wr_misalign;
  logic [31:0]         regv0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_mode, wr_offset, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, wr_misalign, regv0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_mode, wr_offset, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, wr_misalign, regv0
  );
endinterface

// File: rtl/mips_cpu_load_merge.sv
// Combinational partial-load merge; one instance feeds both commit and bypass.
module mips_cpu_load_merge
  import mips_cpu_regfile_pkg::*;
(
  input  logic [31:0] old_val,
  input  logic [31:0] data,
  input  logic [2:0]  mode,
  input  logic [1:0]  offset,
  output logic [31:0] new_val,
  output logic        illegal
);
  merge_t m;

  assign m       = load_merge(old_val, data, mode, offset);
  assign new_val = m.value;
  assign illegal = m.illegal;
endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-read-port MIPS register file: one-stage registered write with merge,
// read bypass of the in-flight write, and a per-register load busy scoreboard.
module mips_cpu_regfile_mp
  import mips_cpu_regfile_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int DEBUG_REG = 2
) (
  input logic                 clk,
  input logic                 reset,
  mips_cpu_regfile_mp_if.slave bus
);
  localparam int            AW  = $clog2(NREGS);
  localparam logic [AW-1:0] DBG = AW'(DEBUG_REG);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [2:0]    mode;
    logic [1:0]    offset;
    logic [31:0]   data;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic [31:0]      regs_q [NREGS];
  logic [31:0]      regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [31:0]      merged;
  logic             illegal;
  logic             s1_legal;

  mips_cpu_load_merge u_merge (
    .old_val (regs_q[s1_q.addr]),
    .data    (s1_q.data),
    .mode    (s1_q.mode),
    .offset  (s1_q.offset),
    .new_val (merged),
    .illegal (illegal)
  );

  // Register 0 is hardwired, so a write aimed at it neither commits nor pulses.
  assign s1_legal = s1_q.valid && !illegal && (s1_q.addr != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = bus.wr_en;
    if (bus.wr_en) begin
      s1_d.addr   = bus.wr_addr;
      s1_d.mode   = bus.wr_mode;
      s1_d.offset = bus.wr_offset;
      s1_d.data   = bus.wr_data;
    end

    regs_d = regs_q;
    if (s1_legal) regs_d[s1_q.addr] = merged;

    // Reservation is applied after the capture clear so it wins on a collision.
    busy_d = busy_q;
    if (bus.wr_en)  busy_d[bus.wr_addr]  = 1'b0;
    if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the array is part of architectural reset state, so it is cleared with the other flops.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      s1_q   <= s1_d;
      busy_q <= busy_d;
      regs_q <= regs_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (bus.rd_addr[i*AW +: AW] != '0) begin
        if (s1_legal && (s1_q.addr == bus.rd_addr[i*AW +: AW]))
          bus.rd_data[i*32 +: 32] = merged;
        else
          bus.rd_data[i*32 +: 32] = regs_q[bus.rd_addr[i*AW +: AW]];
      end
      bus.rd_busy[i] = busy_q[bus.rd_addr[i*AW +: AW]];
    end
  end

  assign bus.wr_misalign = s1_q.valid && illegal && (s1_q.addr != '0);
  assign bus.regv0       = regs_q[DBG];
endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Self-checking bench: directed steps plus random traffic against a byte-lane
// reference model of the register file, write stage and busy scoreboard.
module tb_mips_cpu_regfile_mp;
  import mips_cpu_regfile_pkg::*;

  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_regfile_mp_if #(.NREGS(NREGS), .NREAD(NREAD)) bus ();

  mips_cpu_regfile_mp #(.NREGS(NREGS), .NREAD(NREAD), .DEBUG_REG(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];
  typedef struct {
    bit          valid;
    int          addr;
    int          mode;
    int          off;
    logic [31:0] data;
  } wr_t;
  wr_t pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, value}, built byte by byte from the load semantics.
  function automatic logic [32:0] ref_merge(input logic [31:0] old_v, input logic [31:0] d,
                                            input int mode, input int k);
    logic [7:0] ob [4];
    logic [7:0] db [4];
    logic [7:0] nb [4];
    logic [7:0] fill;
    bit         bad;
    int         hb;
    bad = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ob[j] = old_v[8*j +: 8];
      db[j] = d[8*j +: 8];
    end
    nb = ob;
    case (mode)
      1, 2: begin
        fill  = (mode == 1 && db[k][7]) ? 8'hFF : 8'h00;
        nb[0] = db[k];
        nb[1] = fill; nb[2] = fill; nb[3] = fill;
      end
      3, 4: begin
        bad   = (k % 2) == 1;
        hb    = (k / 2) * 2;
        fill  = (mode == 3 && db[hb+1][7]) ? 8'hFF : 8'h00;
        nb[0] = db[hb];
        nb[1] = db[hb+1];
        nb[2] = fill; nb[3] = fill;
      end
      5: for (int j = 0; j <= k; j++) nb[3-k+j] = db[j];
      6: for (int j = k; j < 4; j++) nb[j-k] = db[j];
      default: nb = db;
    endcase
    return {bad, nb[3], nb[2], nb[1], nb[0]};
  endfunction

  function automatic logic [32:0] pend_merge();
    return ref_merge(m_regs[pend.addr], pend.data, pend.mode, pend.off);
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    logic [32:0] r;
    if (a == 0) return 32'd0;
    if (pend.valid && pend.addr == a) begin
      r = pend_merge();
      if (!r[32]) return r[31:0];
    end
    return m_regs[a];
  endfunction

  function automatic logic exp_misalign();
    logic [32:0] r;
    if (!pend.valid || pend.addr == 0) return 1'b0;
    r = pend_merge();
    return r[32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    pend.valid = 1'b0;
  endtask

  task automatic model_edge();
    logic [32:0] r;
    if (pend.valid && pend.addr != 0) begin
      r = pend_merge();
      if (!r[32]) m_regs[pend.addr] = r[31:0];
    end
    if (bus.wr_en) m_busy[int'(bus.wr_addr)] = 1'b0;
    if (bus.rsv_en && bus.rsv_addr != 0) m_busy[int'(bus.rsv_addr)] = 1'b1;
    pend.valid = bus.wr_en;
    pend.addr  = int'(bus.wr_addr);
    pend.mode  = int'(bus.wr_mode);
    pend.off   = int'(bus.wr_offset);
    pend.data  = bus.wr_data;
  endtask

  task automatic drive(input bit we, input int wa, input int mode, input int off,
                       input logic [31:0] wd, input bit rsv, input int ra,
                       input int rd0, input int rd1);
    bus.wr_en     = we;
    bus.wr_addr   = AW'(wa);
    bus.wr_mode   = 3'(mode);
    bus.wr_offset = 2'(off);
    bus.wr_data   = wd;
    bus.rsv_en    = rsv;
    bus.rsv_addr  = AW'(ra);
    bus.rd_addr   = {AW'(rd1), AW'(rd0)};
  endtask

  task automatic idle(input int rd0, input int rd1);
    drive(1'b0, 0, 0, 0, 32'd0, 1'b0, 0, rd0, rd1);
  endtask

  // Compare every output against the model at the falling edge, then clock it.
  task automatic cycle();
    int a;
    @(negedge clk);
    for (int i = 0; i < NREAD; i++) begin
      a = int'(bus.rd_addr[i*AW +: AW]);
      check($sformatf("rd_data%0d r%0d", i, a), bus.rd_data[i*32 +: 32], exp_read(a));
      check($sformatf("rd_busy%0d r%0d", i, a), {31'd0, bus.rd_busy[i]}, {31'd0, m_busy[a]});
    end
    check("wr_misalign", {31'd0, bus.wr_misalign}, {31'd0, exp_misalign()});
    check("regv0", bus.regv0, m_regs[2]);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " rd_data0"}, bus.rd_data[31:0], 32'd0);
    check({tag, " rd_data1"}, bus.rd_data[63:32], 32'd0);
    check({tag, " rd_busy"}, {30'd0, bus.rd_busy}, 32'd0);
    check({tag, " regv0"}, bus.regv0, 32'd0);
    check({tag, " wr_misalign"}, {31'd0, bus.wr_misalign}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle(2, 5);
    model_reset();
    #12;
    check_zero_outputs("por");
    @(posedge clk);
    #1 reset = 1'b0;

    // WORD write with bypass; debug tap follows one edge after the bypass.
    drive(1, 2, WM_WORD, 0, 32'hDEADBEEF, 0, 0, 2, 0); cycle();
    idle(2, 0);
    #1 check("bypass r2", bus.rd_data[31:0], 32'hDEADBEEF);
    check("regv0 before commit", bus.regv0, 32'd0);
    cycle();
    #1 check("regv0 after commit", bus.regv0, 32'hDEADBEEF);
    cycle();

    // Byte and halfword loads into r5
    drive(1, 5, WM_WORD, 0, 32'h11223344, 0, 0, 5, 2); cycle();
    drive(1, 5, WM_LB,   3, 32'h80FF0000, 0, 0, 5, 2); cycle();
    drive(1, 5, WM_LBU,  3, 32'h80FF0000, 0, 0, 5, 2);
    #1 check("lb off3", bus.rd_data[31:0], 32'hFFFFFF80);
    cycle();
    drive(1, 5, WM_LH,   2, 32'h80FF0000, 0, 0, 5, 2);
    #1 check("lbu off3", bus.rd_data[31:0], 32'h00000080);
    cycle();
    idle(5, 2);
    #1 check("lh off2", bus.rd_data[31:0], 32'hFFFF80FF);
    cycle();

    // LWL then LWR back to back into r6
    drive(1, 6, WM_WORD, 0, 32'hAABBCCDD, 0, 0, 6, 5); cycle();
    drive(1, 6, WM_LWL,  1, 32'h44332211, 0, 0, 6, 5); cycle();
    drive(1, 6, WM_LWR,  1, 32'h88776655, 0, 0, 6, 5);
    #1 check("lwl off1", bus.rd_data[31:0], 32'h2211CCDD);
    cycle();
    idle(6, 5);
    #1 check("lwr off1 chained", bus.rd_data[31:0], 32'h22887766);
    cycle();
    cycle();

    // Misaligned LH drops the write, pulses once, and still clears busy
    drive(1, 7, WM_WORD, 0, 32'h12345678, 0, 0, 7, 6); cycle();
    drive(0, 0, WM_WORD, 0, 32'd0, 1, 7, 7, 6); cycle();
    drive(1, 7, WM_LH, 1, 32'hCAFEF00D, 0, 0, 7, 6);
    #1 check("busy r7 reserved", {31'd0, bus.rd_busy[0]}, 32'd1);
    cycle();
    idle(7, 6);
    #1 check("misalign pulse", {31'd0, bus.wr_misalign}, 32'd1);
    check("r7 unchanged", bus.rd_data[31:0], 32'h12345678);
    check("busy r7 cleared", {31'd0, bus.rd_busy[0]}, 32'd0);
    cycle();
    #1 check("misalign single cycle", {31'd0, bus.wr_misalign}, 32'd0);
    cycle();

    // Reservation beats a same-edge write clear; a later write clears it
    drive(0, 0, WM_WORD, 0, 32'd0, 1, 9, 7, 9); cycle();
    drive(1, 9, WM_WORD, 0, 32'h00000001, 1, 9, 7, 9); cycle();
    idle(7, 9);
    #1 check("busy r9 set wins", {31'd0, bus.rd_busy[1]}, 32'd1);
    cycle();
    drive(1, 9, WM_WORD, 0, 32'h00000002, 0, 0, 7, 9); cycle();
    idle(7, 9);
    #1 check("busy r9 cleared", {31'd0, bus.rd_busy[1]}, 32'd0);
    cycle();

    // Register 0 ignores writes and reservations
    drive(1, 0, WM_WORD, 0, 32'hFFFFFFFF, 1, 0, 0, 9); cycle();
    idle(0, 9);
    #1 check("r0 reads zero", bus.rd_data[31:0], 32'd0);
    check("r0 not busy", {31'd0, bus.rd_busy[0]}, 32'd0);
    check("r0 write no pulse", {31'd0, bus.wr_misalign}, 32'd0);
    cycle();

    // Random traffic, concentrated on a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom(),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      cycle();
    end

    // Asynchronous reset mid-write discards the in-flight write
    drive(1, 2, WM_WORD, 0, 32'h12345678, 1, 4, 2, 4); cycle();
    drive(1, 3, WM_WORD, 0, 32'h0BADF00D, 1, 5, 2, 4);
    #2 reset = 1'b1;
    model_reset();
    #1 check_zero_outputs("async reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2, 3);
    cycle();
    drive(1, 3, WM_LBU, 1, 32'h0000AB00, 0, 0, 2, 3); cycle();
    idle(2, 3);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
